auto_tap_mp: RTL and testbench
==============================

Name: auto_tap_mp

Overview:
- Next-generation X-engine autocorrelation tap: computes a_del × conj(a_ndel) over P parallel lanes and 1 or 2 polarisations.
- Accumulates serially over a run-time-selectable window, then inserts the result onto the daisy-chained accumulation bus.
- Passes antenna streams through and delays the loop stream by an internal circular buffer.
- Sits at the head of each tap chain in the xeng.

Parameters:
- BITWIDTH, 4: bits per real/imag part, two's complement.
- P_FACTOR_BITS, 2: log2 of the number of parallel lanes P.
- N_POL, 2: polarisations per lane, 1 or 2.
- SERIAL_ACC_LEN_BITS, 7: log2 of the maximum serial accumulation length L_MAX.
- N_ANTS, 32: antenna count; sets the loop and sync delays.
- Derived: N_PROD=N_POL², IW=2·BITWIDTH·N_POL·P, W=2·BITWIDTH+1+P_FACTOR_BITS+SERIAL_ACC_LEN_BITS, AW=2·N_PROD·W, LAT=4+P_FACTOR_BITS, LOOP_DELAY=(L_MAX−1)·ceil(N_ANTS/2)+ceil(N_ANTS/2)−floor(N_ANTS/2), SYNC_DELAY=LAT+L_MAX+floor(N_ANTS/2)+1.

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- sync_in  in  1  window sync pulse.
- acc_len  in  SERIAL_ACC_LEN_BITS  window length minus 1; latched on sync_in.
- a_del  in  IW  delayed antenna samples.
- a_ndel  in  IW  undelayed antenna samples.
- a_loop  in  IW  loop input from the last tap.
- acc_in  in  AW  upstream accumulation bus.
- valid_in  in  1  acc_in valid.
- a_del_out  out  IW  combinational passthrough of a_del.
- a_ndel_out  out  IW  combinational passthrough of a_ndel.
- a_end_out  out  IW  a_loop delayed by LOOP_DELAY.
- rst_out  out  1  combinational passthrough of sync_in.
- sync_out  out  1  sync_in delayed by SYNC_DELAY.
- acc_out  out  AW  accumulation bus out.
- valid_out  out  1  acc_out valid.
- collision_out  out  1  sticky: a local dump overwrote an upstream valid word.

Behaviour:
- Packing:
  - Lane 0 occupies the LSBs.
  - A lane is {Y,X}, or X only when N_POL=1.
  - A pol sample is {imag,real}.
  - acc_out words from the LSB: XX, YY, XY, YX. Each word is {imag,real}, W bits per part.
  - Product Pij = a_del.pol_i × conj(a_ndel.pol_j).
- Arithmetic:
  - Full-precision signed; products are 2·BITWIDTH+1 bits.
  - Lane sum through a P_FACTOR_BITS-stage registered adder tree.
  - Accumulator W bits. By construction there is no overflow at L_MAX with full-scale inputs, so no saturation is needed.
- Reset (async): every output register goes to 0 (acc_out, valid_out, sync_out, collision_out, a_end_out). FSM enters IDLE. The loop-buffer fill counter clears.
- FSM, IDLE → RUN:
  - In IDLE, taps only pass acc_in/valid_in through with 1-cycle latency.
  - sync_in=1 in any state: latch L=acc_len+1, clear the sample counter, clear collision_out, discard any partial accumulation without emitting it, then go to RUN.
- RUN:
  - The sample in the cycle after sync_in is sample 0.
  - On sample 0 of each window the accumulator loads the lane sum; on other samples it adds.
  - The counter wraps at L−1 and windows repeat back-to-back until the next sync_in.
- Dump:
  - If the last sample of a window enters at cycle c, then acc_out carries the result with valid_out=1 for exactly one cycle, at cycle c+LAT.
- Passthrough: otherwise acc_out/valid_out equal acc_in/valid_in registered one cycle. This is aligned to the same output register as the dump.
- Collision: if a dump and valid_in (the one registered into that cycle) coincide:
  - the local result wins;
  - the upstream word is dropped;
  - collision_out sets and stays high until the next sync_in or rst.
- acc_len changes outside a sync have no effect.
- Loop buffer:
  - Circular RAM of depth LOOP_DELAY with read/write pointers.
  - a_end_out = a_loop from LOOP_DELAY cycles earlier.
  - a_end_out is forced to 0 until the fill counter reaches LOOP_DELAY after reset, so no X values reach the output.
  - Pointers wrap modulo LOOP_DELAY.
- sync_out: shift-register delay of SYNC_DELAY cycles, cleared by rst.

Test Plan:
All scenarios use BITWIDTH=4, P_FACTOR_BITS=2, N_POL=2, SERIAL_ACC_LEN_BITS=3, N_ANTS=4. This gives W=14, LAT=6, LOOP_DELAY=14, SYNC_DELAY=17.
1. acc_len=7, sync, then all lanes/pols of a_del=a_ndel=1+1j for 8 cycles -> one valid_out pulse 6 cycles after the last sample with XX=YY=XY=YX = 64+0j; no other valid pulses from the tap.
2. All inputs −8−8j, acc_len=7 -> every product word = 4096+0j (no overflow); repeat back-to-back windows -> pulses every 8 cycles.
3. acc_len=1 (L=2), X=1+0j, Y=0+1j on both buses -> per window XX=8, YY=8, XY=0−8j, YX=0+8j; acc_len changed mid-run is ignored until the next sync.
4. Drive valid_in=1 continuously with acc_in=pattern 0xA5… -> passthrough at 1-cycle latency; on the dump cycle the local result appears and collision_out rises and holds; the next sync_in clears it.
5. sync_in at sample 5 of an 8-sample window -> no dump for the partial window; the next dump lands 8 samples after the new sync. rst asserted mid-window -> all outputs 0 immediately; no dump until sync.
6. a_loop=incrementing counter from reset -> a_end_out=0 for the first 14 cycles, then equals a_loop delayed 14 cycles; sync_in pulse -> sync_out pulse 17 cycles later.

Source files
------------

// File: rtl/auto_tap_mp.sv
// -----------------------------------------------------------------------------
// auto_tap_mp: head-of-chain autocorrelation tap for the X-engine.
//
// Computes a_del * conj(a_ndel) for every polarisation pair over P parallel
// lanes. It sums the lanes through a registered adder tree and accumulates
// serially over a window of L = acc_len+1 samples. The window result is
// inserted onto the daisy-chained accumulation bus. The tap also passes the
// antenna streams through, delays the loop stream through a circular buffer,
// and delays the sync pulse.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   sync_in         window sync pulse (acc_len is latched on it)
//   acc_len         window length minus one
//   a_del, a_ndel   delayed / undelayed antenna samples (IW bits)
//   a_loop          loop stream from the last tap of the chain
//   acc_in,valid_in upstream accumulation bus
//   a_del_out       combinational copy of a_del
//   a_ndel_out      combinational copy of a_ndel
//   a_end_out       a_loop delayed by LOOP_DELAY (zero until the buffer fills)
//   rst_out         combinational copy of sync_in
//   sync_out        sync_in delayed by SYNC_DELAY
//   acc_out         accumulation bus out, words XX,YY,XY,YX from the LSB
//   valid_out       acc_out valid
//   collision_out   sticky: a local dump displaced a valid upstream word
// -----------------------------------------------------------------------------
module auto_tap_mp #(
    parameter  int BITWIDTH            = 4,
    parameter  int P_FACTOR_BITS       = 2,
    parameter  int N_POL               = 2,
    parameter  int SERIAL_ACC_LEN_BITS = 7,
    parameter  int N_ANTS              = 32,
    localparam int P                   = 1 << P_FACTOR_BITS,
    localparam int N_PROD              = N_POL * N_POL,
    localparam int IW                  = 2 * BITWIDTH * N_POL * P,
    localparam int W                   = 2 * BITWIDTH + 1 + P_FACTOR_BITS + SERIAL_ACC_LEN_BITS,
    localparam int AW                  = 2 * N_PROD * W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sync_in,
    input  logic [SERIAL_ACC_LEN_BITS-1:0] acc_len,
    input  logic [IW-1:0]                  a_del,
    input  logic [IW-1:0]                  a_ndel,
    input  logic [IW-1:0]                  a_loop,
    input  logic [AW-1:0]                  acc_in,
    input  logic                           valid_in,
    output logic [IW-1:0]                  a_del_out,
    output logic [IW-1:0]                  a_ndel_out,
    output logic [IW-1:0]                  a_end_out,
    output logic                           rst_out,
    output logic                           sync_out,
    output logic [AW-1:0]                  acc_out,
    output logic                           valid_out,
    output logic                           collision_out
);

    localparam int L_MAX      = 1 << SERIAL_ACC_LEN_BITS;
    localparam int HALF_CEIL  = (N_ANTS + 1) / 2;
    localparam int HALF_FLOOR = N_ANTS / 2;
    localparam int LAT        = 4 + P_FACTOR_BITS;
    localparam int LOOP_DELAY = (L_MAX - 1) * HALF_CEIL + HALF_CEIL - HALF_FLOOR;
    localparam int SYNC_DELAY = LAT + L_MAX + HALF_FLOOR + 1;
    localparam int PW         = 2 * BITWIDTH + 1;      // full-precision product width
    localparam int NW         = 2 * N_PROD;            // real/imag parts per result
    localparam int STG        = 2 + P_FACTOR_BITS;     // input reg + product reg + tree levels
    localparam int PTR_W      = $clog2(LOOP_DELAY);
    localparam int FILL_W     = $clog2(LOOP_DELAY + 1);

    // ------------------------------------------------------------------
    // Combinational passthroughs
    // ------------------------------------------------------------------
    assign a_del_out  = a_del;
    assign a_ndel_out = a_ndel;
    assign rst_out    = sync_in;

    // ------------------------------------------------------------------
    // Window control FSM
    // ------------------------------------------------------------------
    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                         r_state, w_state_next;
    logic [SERIAL_ACC_LEN_BITS-1:0] r_cnt, w_cnt_next;
    logic [SERIAL_ACC_LEN_BITS-1:0] r_len_m1, w_len_m1_next;
    logic                           w_first, w_last;

    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_len_m1 <= '0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_len_m1 <= w_len_m1_next;
        end
    end

    // NOTE: every signal is given a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_len_m1_next = r_len_m1;
        w_first       = 1'b0;
        w_last        = 1'b0;
        if (sync_in) begin
            // The sample in the sync cycle is not part of any window.
            w_state_next  = S_RUN;
            w_cnt_next    = '0;
            w_len_m1_next = acc_len;
        end else begin
            case (r_state)
                S_RUN: begin
                    w_first    = (r_cnt == '0);
                    w_last     = (r_cnt == r_len_m1);
                    w_cnt_next = w_last ? '0 : r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Window markers travel alongside the data through the pipeline.
    logic [STG-1:0] r_first_sr, r_last_sr;
    logic           r_dump;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_first_sr <= '0;
            r_last_sr  <= '0;
            r_dump     <= 1'b0;
        end else begin
            r_first_sr <= {r_first_sr[STG-2:0], w_first};
            r_last_sr  <= {r_last_sr[STG-2:0], w_last};
            r_dump     <= r_last_sr[STG-1];
        end
    end

    // ------------------------------------------------------------------
    // Datapath: input reg -> conj products -> adder tree -> accumulator
    // ------------------------------------------------------------------
    function automatic logic signed [BITWIDTH-1:0] part_of(input logic [IW-1:0] bus,
                                                          input int lane, input int pol,
                                                          input int im);
        return $signed(bus[(lane * N_POL + pol) * 2 * BITWIDTH + im * BITWIDTH +: BITWIDTH]);
    endfunction

    // Word order XX, YY, XY, YX: polarisation index of each operand.
    function automatic int pol_del(input int k);
        return (k == 1 || k == 3) ? 1 : 0;
    endfunction

    function automatic int pol_ndel(input int k);
        return (k == 1 || k == 2) ? 1 : 0;
    endfunction

    // Real and imaginary parts of a * conj(b), computed at full precision.
    function automatic logic signed [PW-1:0] cmul_re(input logic signed [BITWIDTH-1:0] ar, ai, br, bi);
        logic signed [PW-1:0] xr, xi, yr, yi;
        xr = PW'(ar);
        xi = PW'(ai);
        yr = PW'(br);
        yi = PW'(bi);
        return xr * yr + xi * yi;
    endfunction

    function automatic logic signed [PW-1:0] cmul_im(input logic signed [BITWIDTH-1:0] ar, ai, br, bi);
        logic signed [PW-1:0] xr, xi, yr, yi;
        xr = PW'(ar);
        xi = PW'(ai);
        yr = PW'(br);
        yi = PW'(bi);
        return xi * yr - xr * yi;
    endfunction

    logic [IW-1:0]        r_del, r_ndel;
    logic signed [W-1:0]  w_prod [P][NW];
    // Heap-ordered tree: node i sums nodes 2i+1 and 2i+2; leaves are P-1..2P-2.
    logic signed [W-1:0]  r_node [2*P-1][NW];
    logic signed [W-1:0]  r_acc  [NW];

    always_comb begin
        for (int p = 0; p < P; p++) begin
            for (int k = 0; k < N_PROD; k++) begin
                w_prod[p][2*k]   = W'(cmul_re(part_of(r_del, p, pol_del(k), 0),
                                              part_of(r_del, p, pol_del(k), 1),
                                              part_of(r_ndel, p, pol_ndel(k), 0),
                                              part_of(r_ndel, p, pol_ndel(k), 1)));
                w_prod[p][2*k+1] = W'(cmul_im(part_of(r_del, p, pol_del(k), 0),
                                              part_of(r_del, p, pol_del(k), 1),
                                              part_of(r_ndel, p, pol_ndel(k), 0),
                                              part_of(r_ndel, p, pol_ndel(k), 1)));
            end
        end
    end

    // NOTE: pure datapath registers and the loop RAM carry no reset. Their
    // contents only reach an output when qualified by the reset window
    // markers or the loop-buffer fill counter.
    always_ff @(posedge clk) begin
        r_del  <= a_del;
        r_ndel <= a_ndel;
        for (int i = 0; i < P; i++) begin
            r_node[P-1+i] <= w_prod[i];
        end
        for (int i = 0; i < P - 1; i++) begin
            for (int m = 0; m < NW; m++) begin
                r_node[i][m] <= r_node[2*i+1][m] + r_node[2*i+2][m];
            end
        end
        // The first sample of a window reloads, which also discards any
        // partial sum left over from a window cut short by sync_in.
        for (int m = 0; m < NW; m++) begin
            r_acc[m] <= r_first_sr[STG-1] ? r_node[0][m] : r_acc[m] + r_node[0][m];
        end
    end

    // ------------------------------------------------------------------
    // Output register: local dump wins over the upstream word
    // ------------------------------------------------------------------
    logic [AW-1:0] r_acc_out;
    logic          r_valid_out;
    logic          r_collision;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_out   <= '0;
            r_valid_out <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            if (r_dump) begin
                for (int m = 0; m < NW; m++) begin
                    r_acc_out[m*W +: W] <= r_acc[m];
                end
                r_valid_out <= 1'b1;
            end else begin
                r_acc_out   <= acc_in;
                r_valid_out <= valid_in;
            end
            r_collision <= (r_collision & ~sync_in) | (r_dump & valid_in);
        end
    end

    assign acc_out       = r_acc_out;
    assign valid_out     = r_valid_out;
    assign collision_out = r_collision;

    // ------------------------------------------------------------------
    // Loop buffer: circular RAM, read pointer one slot ahead of the write
    // pointer so the registered read lands exactly LOOP_DELAY cycles late.
    // ------------------------------------------------------------------
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(LOOP_DELAY - 1)) ? '0 : ptr + 1'b1;
    endfunction

    logic [IW-1:0]     r_loop_mem [LOOP_DELAY];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [FILL_W-1:0] r_fill;
    logic [IW-1:0]     r_end;

    always_ff @(posedge clk) begin
        r_loop_mem[r_wr_ptr] <= a_loop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= PTR_W'(1);
            r_fill   <= '0;
            r_end    <= '0;
        end else begin
            r_wr_ptr <= ptr_inc(r_wr_ptr);
            r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (r_fill != FILL_W'(LOOP_DELAY)) begin
                r_fill <= r_fill + 1'b1;
            end
            // The slot read here was written LOOP_DELAY-1 edges ago; before
            // that many writes have happened it holds no valid data.
            r_end <= (r_fill >= FILL_W'(LOOP_DELAY - 1)) ? r_loop_mem[r_rd_ptr] : '0;
        end
    end

    assign a_end_out = r_end;

    // ------------------------------------------------------------------
    // Sync delay line
    // ------------------------------------------------------------------
    logic [SYNC_DELAY-1:0] r_sync_sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_sr <= '0;
        end else begin
            r_sync_sr <= {r_sync_sr[SYNC_DELAY-2:0], sync_in};
        end
    end

    assign sync_out = r_sync_sr[SYNC_DELAY-1];

endmodule

// File: tb/tb_auto_tap_mp.sv
// -----------------------------------------------------------------------------
// Testbench for auto_tap_mp with BITWIDTH=4, P=4, N_POL=2, L_MAX=8, N_ANTS=4
// (W=14, LAT=6, LOOP_DELAY=14, SYNC_DELAY=17). Inputs are driven and outputs
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_auto_tap_mp;

    localparam int IW = 64;
    localparam int AW = 112;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sync_in = 1'b0;
    logic [2:0]    acc_len = '0;
    logic [IW-1:0] a_del = '0, a_ndel = '0, a_loop = '0;
    logic [AW-1:0] acc_in = '0;
    logic          valid_in = 1'b0;
    logic [IW-1:0] a_del_out, a_ndel_out, a_end_out;
    logic          rst_out, sync_out, valid_out, collision_out;
    logic [AW-1:0] acc_out;

    int n_checks = 0;
    int n_fail   = 0;

    auto_tap_mp #(
        .BITWIDTH(4), .P_FACTOR_BITS(2), .N_POL(2),
        .SERIAL_ACC_LEN_BITS(3), .N_ANTS(4)
    ) dut (
        .clk(clk), .rst(rst), .sync_in(sync_in), .acc_len(acc_len),
        .a_del(a_del), .a_ndel(a_ndel), .a_loop(a_loop),
        .acc_in(acc_in), .valid_in(valid_in),
        .a_del_out(a_del_out), .a_ndel_out(a_ndel_out), .a_end_out(a_end_out),
        .rst_out(rst_out), .sync_out(sync_out), .acc_out(acc_out),
        .valid_out(valid_out), .collision_out(collision_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Same complex sample on every lane: lane = {Y,X}, sample = {imag,real}.
    function automatic logic [IW-1:0] pack_bus(input int xr, xi, yr, yi);
        logic [15:0] lane;
        lane = {4'(yi), 4'(yr), 4'(xi), 4'(xr)};
        return {4{lane}};
    endfunction

    function automatic logic [AW-1:0] pack_acc(input int xxr, xxi, yyr, yyi,
                                               input int xyr, xyi, yxr, yxi);
        return {14'(yxi), 14'(yxr), 14'(xyi), 14'(xyr),
                14'(yyi), 14'(yyr), 14'(xxi), 14'(xxr)};
    endfunction

    function automatic logic [AW-1:0] pat(input int i);
        logic [AW-1:0] base;
        base = {14{8'hA5}};
        return base ^ AW'(i);
    endfunction

    function automatic logic [IW-1:0] loop_val(input int t);
        return {32'(t) ^ 32'hC0DE0000, 32'(t * 3 + 1)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        sync_in  = 1'b0;
        valid_in = 1'b0;
        acc_in   = '0;
        a_loop   = '0;
        repeat (2) @(negedge clk);
        check("rst_acc_out", acc_out, '0);
        check("rst_valid_out", valid_out, 0);
        check("rst_collision", collision_out, 0);
        check("rst_sync_out", sync_out, 0);
        check("rst_a_end_out", a_end_out, '0);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [2:0]    len;
        logic [2:0]    len_mid;   // acc_len driven after the sync; must be ignored
        logic [IW-1:0] del;
        logic [IW-1:0] ndel;
        logic [AW-1:0] exp;
        int            nwin;
    } vec_t;

    vec_t          vecs [4];
    int            win_len, last_c;
    logic          exp_v;
    logic [AW-1:0] prev_in, res;

    initial begin
        // 1+1j everywhere: |1+j|^2 = 2, x4 lanes x8 samples = 64.
        vecs[0] = '{3'd7, 3'd7, pack_bus(1, 1, 1, 1), pack_bus(1, 1, 1, 1),
                    pack_acc(64, 0, 64, 0, 64, 0, 64, 0), 1};
        // Full scale -8-8j: 128 x4 x8 = 4096, no overflow in 14 bits.
        vecs[1] = '{3'd7, 3'd7, pack_bus(-8, -8, -8, -8), pack_bus(-8, -8, -8, -8),
                    pack_acc(4096, 0, 4096, 0, 4096, 0, 4096, 0), 3};
        // X=1, Y=j, L=2: XX=YY=8, XY=-8j, YX=+8j.
        vecs[2] = '{3'd1, 3'd6, pack_bus(1, 0, 0, 1), pack_bus(1, 0, 0, 1),
                    pack_acc(8, 0, 8, 0, 0, -8, 0, 8), 4};
        // del X=1+2j Y=-3, ndel X=2-1j Y=1+1j, L=3 (x12):
        // XX=5j, YY=-3+3j, XY=3+j, YX=-6-3j per sample/lane.
        vecs[3] = '{3'd2, 3'd0, pack_bus(1, 2, -3, 0), pack_bus(2, -1, 1, 1),
                    pack_acc(0, 60, -36, 36, 36, 12, -72, -36), 2};

        // ---------------- table-driven window tests ----------------
        for (int e = 0; e < 4; e++) begin
            do_reset();
            a_del   = vecs[e].del;
            a_ndel  = vecs[e].ndel;
            acc_len = vecs[e].len;
            sync_in = 1'b1;
            #1;
            check($sformatf("v%0d_rst_out", e), rst_out, 1);
            check($sformatf("v%0d_a_del_out", e), a_del_out, vecs[e].del);
            check($sformatf("v%0d_a_ndel_out", e), a_ndel_out, vecs[e].ndel);
            cyc();
            sync_in = 1'b0;
            acc_len = vecs[e].len_mid;
            win_len = int'(vecs[e].len) + 1;
            last_c  = (vecs[e].nwin + 1) * win_len + 5;
            for (int c = 1; c <= last_c; c++) begin
                exp_v = (c > 6) && ((c - 6) % win_len == 0);
                check($sformatf("v%0d_valid_c%0d", e, c), valid_out, exp_v);
                check($sformatf("v%0d_acc_c%0d", e, c), acc_out, exp_v ? vecs[e].exp : '0);
                cyc();
            end
        end

        // ---------------- collision with continuous upstream traffic ----------------
        do_reset();
        a_del    = pack_bus(1, 0, 0, 1);
        a_ndel   = pack_bus(1, 0, 0, 1);
        valid_in = 1'b1;
        acc_in   = pat(0);
        cyc();
        check("idle_pass_acc", acc_out, pat(0));
        check("idle_pass_valid", valid_out, 1);
        sync_in = 1'b1;
        acc_len = 3'd7;
        acc_in  = pat(1);
        prev_in = pat(1);
        cyc();
        sync_in = 1'b0;
        res = pack_acc(32, 0, 32, 0, 0, -32, 0, 32);
        for (int c = 1; c <= 18; c++) begin
            check($sformatf("col_acc_c%0d", c), acc_out, (c == 14) ? res : prev_in);
            check($sformatf("col_valid_c%0d", c), valid_out, 1);
            check($sformatf("col_flag_c%0d", c), collision_out, c >= 14);
            acc_in  = pat(c + 1);
            prev_in = pat(c + 1);
            cyc();
        end
        sync_in = 1'b1;
        cyc();
        sync_in = 1'b0;
        check("col_cleared_by_sync", collision_out, 0);

        // ---------------- sync in mid-window, then reset mid-window ----------------
        do_reset();
        a_del   = pack_bus(-8, -8, -8, -8);
        a_ndel  = pack_bus(-8, -8, -8, -8);
        acc_len = 3'd7;
        sync_in = 1'b1;
        cyc();
        sync_in = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("part_old_valid_c%0d", c), valid_out, 0);
            cyc();
        end
        // Sample slot 5 of the first window: restart with new data.
        sync_in = 1'b1;
        a_del   = pack_bus(1, 1, 1, 1);
        a_ndel  = pack_bus(1, 1, 1, 1);
        cyc();
        sync_in = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            check($sformatf("part_new_valid_c%0d", c), valid_out, c == 14);
            check($sformatf("part_new_acc_c%0d", c), acc_out,
                  (c == 14) ? pack_acc(64, 0, 64, 0, 64, 0, 64, 0) : '0);
            cyc();
        end
        valid_in = 1'b1;
        acc_in   = pat(99);
        cyc();
        check("pre_rst_pass", acc_out, pat(99));
        cyc();
        check("part_sync_out", sync_out, 1);
        rst = 1'b1;
        #1;
        check("async_rst_acc", acc_out, '0);
        check("async_rst_valid", valid_out, 0);
        check("async_rst_sync_out", sync_out, 0);
        check("async_rst_collision", collision_out, 0);
        check("async_rst_a_end", a_end_out, '0);
        @(negedge clk);
        rst      = 1'b0;
        valid_in = 1'b0;
        acc_in   = '0;
        for (int c = 1; c <= 20; c++) begin
            cyc();
            check($sformatf("post_rst_valid_c%0d", c), valid_out, 0);
        end

        // ---------------- loop buffer and sync delay ----------------
        do_reset();
        a_loop = loop_val(0);
        for (int t = 0; t < 40; t++) begin
            cyc();
            check($sformatf("loop_t%0d", t), a_end_out, (t >= 13) ? loop_val(t - 13) : '0);
            check($sformatf("sync_out_t%0d", t), sync_out, t == 19);
            a_loop  = loop_val(t + 1);
            sync_in = (t + 1 == 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
